// File: rtl/data_mem_stage_pkg.sv
// Shared encodings for the data memory stage: access sizes, branch conditions
// and the access FSM state type.
package data_mem_stage_pkg;

  typedef enum logic [1:0] {
    MemByte = 2'b00,
    MemHalf = 2'b01,
    MemWord = 2'b10,
    MemRsvd = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    BrEq  = 2'b00,
    BrNe  = 2'b01,
    BrLtz = 2'b10,
    BrGez = 2'b11
  } br_cond_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } mem_state_e;

  // Reserved size encoding behaves as a full-width access.
  function automatic logic size_is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port data RAM: combinational read, synchronous write with per-byte enables.
// Contents are never reset.
module data_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  clk_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (be_i[b]) begin
        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_stage.sv
// Memory-access pipeline stage: branch resolution, alignment check, and a
// multi-cycle load/store FSM in front of a byte-enabled data RAM.
module data_mem_stage
  import data_mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inValid,
  input  logic              isBranch,
  input  logic [1:0]        branchCond,
  input  logic              isAluOutputZero,
  output logic              shouldBranch,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        memSize,
  input  logic              memUnsigned,
  input  logic [DATA_W-1:0] aluOutput,
  input  logic [DATA_W-1:0] registerRt,
  output logic [DATA_W-1:0] memoryData,
  output logic              stall,
  output logic              outValid,
  output logic              misaligned
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(NB);
  localparam int unsigned IDX_HI = ADDR_W + OFF_W - 1;
  localparam logic [1:0]  CntLoad = 2'(LATENCY - 1);

  mem_state_e        state_q;
  logic [1:0]        cnt_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              out_valid_q;

  // Request captured on accept; the address keeps only index and lane bits.
  logic              rd_q, wr_q, uns_q;
  logic [1:0]        size_q;
  logic [IDX_HI:0]   addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              cur_rd, cur_wr, cur_uns;
  logic [1:0]        cur_size;
  logic [IDX_HI:0]   cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [OFF_W-1:0]  cur_off;

  logic              is_mem, accept, commit;
  logic [NB-1:0]     size_mask, ram_be;
  logic [DATA_W-1:0] ram_rdata, lane, load_ext;
  logic              unused_addr;

  assign unused_addr = ^aluOutput;

  // Branch resolution is purely combinational and ignores the memory FSM.
  always_comb begin
    logic cond;
    cond = 1'b0;
    case (br_cond_e'(branchCond))
      BrEq:    cond = isAluOutputZero;
      BrNe:    cond = ~isAluOutputZero;
      BrLtz:   cond = aluOutput[DATA_W-1];
      BrGez:   cond = ~aluOutput[DATA_W-1];
      default: cond = 1'b0;
    endcase
    shouldBranch = inValid & isBranch & cond;
  end

  always_comb begin
    logic mis_half, mis_word;
    mis_half   = (mem_size_e'(memSize) == MemHalf) & aluOutput[0];
    mis_word   = size_is_word(memSize) & (aluOutput[OFF_W-1:0] != '0);
    is_mem     = memRead | memWrite;
    misaligned = inValid & is_mem & (mis_half | mis_word);
  end

  assign accept = (state_q == StIdle) & inValid & is_mem & ~misaligned;

  // In IDLE the live inputs drive the access so a single-cycle latency can
  // complete on the accept edge; afterwards the captured request is used.
  always_comb begin
    if (state_q == StIdle) begin
      cur_rd    = memRead;
      cur_wr    = memWrite;
      cur_uns   = memUnsigned;
      cur_size  = memSize;
      cur_addr  = aluOutput[IDX_HI:0];
      cur_wdata = registerRt;
    end else begin
      cur_rd    = rd_q;
      cur_wr    = wr_q;
      cur_uns   = uns_q;
      cur_size  = size_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    cur_off = cur_addr[OFF_W-1:0];
  end

  // The access finishes on the edge that enters DONE.
  assign commit = (LATENCY == 1) ? accept : ((state_q == StBusy) & (cnt_q == 2'd1));
  assign stall  = accept | (state_q == StBusy);

  always_comb begin
    size_mask = '1;
    case (mem_size_e'(cur_size))
      MemByte: size_mask = NB'(1);
      MemHalf: size_mask = NB'(3);
      default: size_mask = '1;
    endcase
    ram_be = (commit & cur_wr & ~reset) ? NB'(size_mask << cur_off) : '0;
  end

  data_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_data_ram (
    .clk_i   (clock),
    .be_i    (ram_be),
    .addr_i  (cur_addr[IDX_HI:OFF_W]),
    .wdata_i (cur_wdata << {cur_off, 3'b000}),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    lane     = ram_rdata >> {cur_off, 3'b000};
    load_ext = lane;
    case (mem_size_e'(cur_size))
      MemByte: load_ext = {{(DATA_W-8){~cur_uns & lane[7]}}, lane[7:0]};
      MemHalf: load_ext = {{(DATA_W-16){~cur_uns & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      rd_q    <= memRead;
      wr_q    <= memWrite;
      uns_q   <= memUnsigned;
      size_q  <= memSize;
      addr_q  <= aluOutput[IDX_HI:0];
      wdata_q <= registerRt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      mem_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= commit;
      if (commit & cur_rd) begin
        mem_data_q <= load_ext;
      end
      case (state_q)
        StIdle: begin
          if (accept) begin
            cnt_q   <= CntLoad;
            state_q <= (LATENCY == 1) ? StDone : StBusy;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign memoryData = mem_data_q;
  assign outValid   = out_valid_q;

endmodule

// File: doc/data_mem_stage.md
DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 8, word-index bits; memory depth SHALL be 2**ADDR_W words.
REQ-003 Parameter LATENCY, default 1, cycles per memory access; legal range 1..4.
REQ-004 Port clock  in  1  single clock, all state updates on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high.
REQ-006 Port inValid  in  1  stage holds a live instruction.
REQ-007 Port isBranch  in  1  instruction is a conditional branch.
REQ-008 Port branchCond  in  2  00 EQ (zero), 01 NE (!zero), 10 LTZ (aluOutput MSB), 11 GEZ (!MSB).
REQ-009 Port isAluOutputZero  in  1  ALU zero flag.
REQ-010 Port shouldBranch  out  1  branch taken.
REQ-011 Port memRead / memWrite  in  1 each  load / store request; both high is illegal.
REQ-012 Port memSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-013 Port memUnsigned  in  1  zero-extend loads when high, sign-extend when low.
REQ-014 Port aluOutput  in  DATA_W  effective byte address.
REQ-015 Port registerRt  in  DATA_W  store data, right-aligned.
REQ-016 Port memoryData  out  DATA_W  extended load result.
REQ-017 Port stall  out  1  upstream SHALL hold all inputs stable while high.
REQ-018 Port outValid  out  1  one-cycle pulse: access complete.
REQ-019 Port misaligned  out  1  address not aligned to memSize.

Function
REQ-020 shouldBranch SHALL equal inValid & isBranch & condition(branchCond), combinational, independent of the memory FSM.
REQ-021 misaligned SHALL be inValid & (memRead|memWrite) & (half & addr[0] | word & addr[1:0]!=0), combinational; DATA_W=64 word/dword checks use addr[2:0].
REQ-022 A misaligned request SHALL perform no access, raise no stall, pulse no outValid, and leave memory unchanged.
REQ-023 Word index SHALL be aluOutput[ADDR_W+log2(DATA_W/8)-1 : log2(DATA_W/8)]; higher address bits ignored (wrap-around).
REQ-024 FSM states IDLE, BUSY, DONE; 2-bit latency counter.
REQ-025 IDLE -> BUSY when inValid & (memRead|memWrite) & !misaligned; request captured, counter loaded with LATENCY-1.
REQ-026 BUSY decrements counter; BUSY -> DONE when counter is 0.
REQ-027 stall SHALL be high in the IDLE accept cycle and in every BUSY cycle: exactly LATENCY cycles per access; low in DONE.
REQ-028 DONE SHALL last one cycle with outValid=1, ignore inputs, and return to IDLE; back-to-back accesses therefore issue every LATENCY+1 cycles.
REQ-029 Store SHALL commit on the BUSY->DONE edge using byte enables from memSize and addr low bits; unselected lanes unchanged.
REQ-030 Load SHALL select the addressed lane, extend per memUnsigned, and register into memoryData on the BUSY->DONE edge; memoryData holds until the next load completes.
REQ-031 Stores and non-memory instructions SHALL NOT change memoryData.

Reset
REQ-032 Reset SHALL force state IDLE, counter 0, memoryData 0, outValid 0, stall 0.
REQ-033 Reset during BUSY SHALL abort the access; a pending store SHALL NOT be written.
REQ-034 Memory array contents SHALL NOT be reset.

Structure
REQ-035 Package data_mem_stage_pkg SHALL hold memSize encodings, branchCond encodings and the FSM state type.
REQ-036 Sub-module data_ram: single-port, synchronous write with per-byte enables, DATA_W x 2**ADDR_W; all FSM, alignment and extension logic stays in data_mem_stage.

Verification
REQ-037 LATENCY=1: sw 0xDEADBEEF @0x10, then lw @0x10 -> stall 1 cycle each, outValid next cycle, memoryData=0xDEADBEEF.
REQ-038 sb 0x80 @0x13 over 0x00000000, then lb and lbu @0x13 -> word reads 0x80000000, lb=0xFFFFFF80, lbu=0x00000080.
REQ-039 lh @0x11 and lw @0x12 -> misaligned=1, stall=0, outValid=0, memory unchanged.
REQ-040 LATENCY=3: lw -> stall high exactly 3 cycles, outValid on 4th; reset asserted in 2nd BUSY cycle of an sw -> IDLE next cycle, target word unchanged.
REQ-041 isBranch with branchCond 00/01/10/11, zero=1, aluOutput=0x80000000 -> shouldBranch 1/0/1/0; inValid=0 -> 0.
REQ-042 ADDR_W=8: sw 0x11111111 @0x400, lw @0x000 -> 0x11111111 (address wrap).
